// File: rtl/codec_sample_port_pkg.sv
// Shared constants, types and small helpers for the I2S codec sample port.
package codec_sample_port_pkg;

  localparam int SAMPLE_W    = 24;  // audio sample width
  localparam int I2S_DELAY   = 1;   // bclk periods between an lrck edge and the MSB
  localparam int SYNC_STAGES = 2;   // flops in each input synchronizer
  localparam int BIT_CNT_W   = 6;   // wide enough for a 32-bit slot plus headroom

  typedef logic [BIT_CNT_W-1:0] bit_cnt_t;
  typedef logic [SAMPLE_W-1:0]  sample_t;

  // RX counts bclk rising edges after lrck falls; edge I2S_DELAY+1 carries the MSB.
  localparam bit_cnt_t RX_FIRST_BIT = bit_cnt_t'(I2S_DELAY + 1);
  localparam bit_cnt_t RX_LAST_BIT  = bit_cnt_t'(I2S_DELAY + SAMPLE_W);

  // TX counts bclk falling edges after an lrck edge; edge I2S_DELAY drives the MSB.
  localparam bit_cnt_t TX_FIRST_BIT = bit_cnt_t'(I2S_DELAY);
  localparam bit_cnt_t TX_LAST_BIT  = bit_cnt_t'(I2S_DELAY + SAMPLE_W - 1);

  // Edge pulses derived from a synchronized input.
  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  // True when a bit index lies inside the inclusive [lo, hi] window.
  function automatic logic in_window(bit_cnt_t idx, bit_cnt_t lo, bit_cnt_t hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

  // Counter increment that sticks at all-ones so a stalled lrck never wraps.
  function automatic bit_cnt_t sat_inc(bit_cnt_t v);
    return (v == '1) ? v : v + bit_cnt_t'(1);
  endfunction

endpackage

// File: rtl/codec_sample_port_sample_fifo.sv
// Show-ahead FIFO: rd_data presents the head whenever empty is low.
// A push while full is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t FULL_COUNT = cnt_t'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  cnt_t             count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Head is gated to zero when empty so stale RAM contents never leak out.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy update; push+pop together leaves the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + cnt_t'(1);
      2'b01:   count_d = count_q - cnt_t'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage; contents need no reset because the head output is gated.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/codec_sample_port.sv
// I2S codec sample port: oversamples bclk/lrck/adcdat on fast_clock, collects
// left-channel ADC samples into an RX FIFO and plays TX FIFO samples on both
// DAC channels.
module codec_sample_port
  import codec_sample_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                fast_clock,
  input  logic                reset,
  input  logic                bclk,
  input  logic                lrck,
  input  logic                adcdat,
  output logic                dacdat,
  output logic                read_ready,
  input  logic                read_enable,
  output logic [SAMPLE_W-1:0] read_data,
  output logic                write_ready,
  input  logic                write_enable,
  input  logic [SAMPLE_W-1:0] write_data,
  output logic                overrun,
  output logic                underrun
);

  localparam int SYNC_BITS = 3;  // {bclk, lrck, adcdat}

  // Synchronizer chain and edge-detect history.
  logic [SYNC_STAGES-1:0][SYNC_BITS-1:0] sync_q, sync_d;
  logic  bclk_prev_q, bclk_prev_d;
  logic  lrck_prev_q, lrck_prev_d;
  logic  bclk_s, lrck_s, adc_s;
  edge_t bclk_edge, lrck_edge;

  // RX state.
  logic     rx_active_q, rx_active_d;
  bit_cnt_t rx_cnt_q, rx_cnt_d;
  bit_cnt_t rx_idx;
  sample_t  rx_shift_q, rx_shift_d;
  logic     rx_push_q, rx_push_d;
  logic     overrun_q, overrun_d;
  logic     rx_full, rx_empty;

  // TX state.
  bit_cnt_t tx_cnt_q, tx_cnt_d;
  bit_cnt_t tx_idx;
  sample_t  tx_shift_q, tx_shift_d;
  sample_t  tx_hold_q, tx_hold_d;
  logic     dacdat_q, dacdat_d;
  logic     underrun_q, underrun_d;
  logic     tx_pop;
  sample_t  tx_head;
  logic     tx_full, tx_empty;

  assign bclk_s = sync_q[SYNC_STAGES-1][2];
  assign lrck_s = sync_q[SYNC_STAGES-1][1];
  assign adc_s  = sync_q[SYNC_STAGES-1][0];

  // Shift the raw codec pins through the synchronizer and remember the last value.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], bclk, lrck, adcdat};
    bclk_prev_d = bclk_s;
    lrck_prev_d = lrck_s;
  end

  // Edge pulses are one fast_clock cycle wide, taken from synchronized levels.
  always_comb begin
    bclk_edge.rise = bclk_s & ~bclk_prev_q;
    bclk_edge.fall = ~bclk_s & bclk_prev_q;
    lrck_edge.rise = lrck_s & ~lrck_prev_q;
    lrck_edge.fall = ~lrck_s & lrck_prev_q;
  end

  // Synchronizer and edge-history registers.
  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      bclk_prev_q <= 1'b0;
      lrck_prev_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      bclk_prev_q <= bclk_prev_d;
      lrck_prev_q <= lrck_prev_d;
    end
  end

  // RX framing: lrck fall arms a left frame, any other lrck edge abandons it,
  // and the capture window closes with a push request after the last bit.
  always_comb begin
    rx_active_d = rx_active_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_push_d   = 1'b0;
    rx_idx      = sat_inc(rx_cnt_q);
    if (lrck_edge.fall) begin
      rx_active_d = 1'b1;
      rx_cnt_d    = '0;
      rx_shift_d  = '0;
    end else if (lrck_edge.rise) begin
      rx_active_d = 1'b0;
    end else if (bclk_edge.rise && rx_active_q) begin
      rx_cnt_d = rx_idx;
      if (in_window(rx_idx, RX_FIRST_BIT, RX_LAST_BIT)) begin
        rx_shift_d = {rx_shift_q[SAMPLE_W-2:0], adc_s};
      end
      if (rx_idx == RX_LAST_BIT) begin
        rx_push_d   = 1'b1;
        rx_active_d = 1'b0;
      end
    end
  end

  // A completed sample is lost only if the FIFO stays full through the push cycle.
  always_comb begin
    overrun_d = overrun_q | (rx_push_q & rx_full & ~read_enable);
  end

  // RX registers.
  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_push_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_active_q <= rx_active_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_push_q   <= rx_push_d;
      overrun_q   <= overrun_d;
    end
  end

  // TX framing: lrck fall fetches a new sample (or silence on underrun), each
  // lrck edge reloads the shifter, and bclk falls shift bits out MSB first.
  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_hold_d  = tx_hold_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;
    tx_pop     = 1'b0;
    tx_idx     = sat_inc(tx_cnt_q);
    if (lrck_edge.fall) begin
      tx_cnt_d = '0;
      dacdat_d = 1'b0;
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_hold_d  = tx_head;
        tx_shift_d = tx_head;
      end else begin
        tx_hold_d  = '0;
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end else if (lrck_edge.rise) begin
      tx_cnt_d   = '0;
      tx_shift_d = tx_hold_q;
      dacdat_d   = 1'b0;
    end else if (bclk_edge.fall) begin
      tx_cnt_d = tx_idx;
      if (in_window(tx_idx, TX_FIRST_BIT, TX_LAST_BIT)) begin
        dacdat_d   = tx_shift_q[SAMPLE_W-1];
        tx_shift_d = {tx_shift_q[SAMPLE_W-2:0], 1'b0};
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  // TX registers.
  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      tx_cnt_q   <= '0;
      tx_shift_q <= '0;
      tx_hold_q  <= '0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      tx_shift_q <= tx_shift_d;
      tx_hold_q  <= tx_hold_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
    end
  end

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .clk     (fast_clock),
    .rst     (reset),
    .push    (rx_push_q),
    .wr_data (rx_shift_q),
    .pop     (read_enable),
    .rd_data (read_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .clk     (fast_clock),
    .rst     (reset),
    .push    (write_enable),
    .wr_data (write_data),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .full    (tx_full),
    .empty   (tx_empty)
  );

  assign read_ready  = ~rx_empty;
  assign write_ready = ~tx_full;
  assign dacdat      = dacdat_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;

endmodule

// File: doc/codec_sample_port.md
CODEC_SAMPLE_PORT -- requirements
Module: codec_sample_port

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of 24-bit entries in each of the RX and TX FIFOs (power of two, 2..16).
REQ-002 fast_clock  input  1  sole system clock; it SHALL be at least 8x the bclk frequency.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 bclk  input  1  codec bit clock; asynchronous to fast_clock.
REQ-005 lrck  input  1  codec left/right clock, shared by ADC and DAC directions; low = left, high = right.
REQ-006 adcdat  input  1  serial ADC data from the codec, I2S format.
REQ-007 dacdat  output  1  serial DAC data to the codec, I2S format.
REQ-008 read_ready  output  1  high while an RX sample is available.
REQ-009 read_enable  input  1  consumer acknowledge; pops the RX FIFO.
REQ-010 read_data  output  24  RX FIFO head, show-ahead, valid while read_ready=1.
REQ-011 write_ready  output  1  high while the TX FIFO has space.
REQ-012 write_enable  input  1  producer strobe; pushes write_data.
REQ-013 write_data  input  24  sample to be played.
REQ-014 overrun  output  1  sticky flag: an RX sample was dropped.
REQ-015 underrun  output  1  one-cycle pulse: a TX frame started with the TX FIFO empty.

Function
REQ-016 bclk, lrck and adcdat SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals, giving 2-3 fast_clock cycles of latency.
REQ-017 RX: an lrck falling edge (left frame start) SHALL clear the bit counter; the first bclk rising edge after it SHALL be skipped (I2S one-bit delay).
REQ-018 RX: the next 24 bclk rising edges SHALL shift adcdat in MSB first; further bits in the frame SHALL be ignored; right-channel frames SHALL be ignored.
REQ-019 RX: on the 24th bit the sample SHALL be pushed to the RX FIFO in the following fast_clock cycle; if the FIFO is full, the sample SHALL be dropped and overrun set to 1 until reset.
REQ-020 RX: an lrck edge arriving before 24 bits are received SHALL abort the frame and push nothing.
REQ-021 read_ready SHALL equal RX-FIFO-not-empty; a pop SHALL occur on a cycle where read_ready=1 and read_enable=1.
REQ-022 read_enable while read_ready=0 SHALL be ignored.
REQ-023 After a pop, read_data SHALL show the next entry in the next cycle, or read_ready SHALL fall if the FIFO is now empty.
REQ-024 write_ready SHALL equal TX-FIFO-not-full; a push SHALL occur on a cycle where write_ready=1 and write_enable=1; write_enable while full SHALL be ignored.
REQ-025 Simultaneous push and pop on the same FIFO SHALL both take effect: count unchanged, order preserved, including when full or empty.
REQ-026 TX: on an lrck falling edge, if the TX FIFO is non-empty, pop one sample into the left and right holding register; if empty, load 0 and pulse underrun for one cycle.
REQ-027 TX: on each lrck edge the shift register SHALL load the holding sample, so the same sample plays on both channels.
REQ-028 TX: dacdat SHALL update only on synchronized bclk falling edges; the first falling edge after an lrck edge SHALL drive the MSB; bits 25 and beyond in the frame SHALL be 0.
REQ-029 TX and RX SHALL operate concurrently and independently.

Reset
REQ-030 While reset=1: read_ready=0, read_data=0, write_ready=1, dacdat=0, overrun=0, underrun=0, both FIFOs empty, counters and shift and holding registers 0, synchronizers 0.
REQ-031 After reset release, RX SHALL ignore bits until the first lrck falling edge; a partial frame in progress at reset SHALL be discarded, with no push.
REQ-032 After reset release, TX SHALL output 0 until the first lrck falling edge.

Structure
REQ-033 A shared package SHALL hold SAMPLE_W=24, I2S_DELAY=1 and the synchronizer depth of 2.
REQ-034 One sub-module, sample_fifo (parameters WIDTH and DEPTH, show-ahead, with full and empty outputs), SHALL be instantiated twice, for RX and TX.
REQ-035 The block SHALL contain no other state machines beyond the per-direction bit counters and frame flags.

Verification
REQ-036 Codec model sends left=24'hA5C3F1, right=24'h123456 -> read_ready rises within 6 fast_clock cycles of bit 24; read_data=24'hA5C3F1; the right sample is never delivered.
REQ-037 Write 24'h800001, then run 2 frames -> dacdat carries 800001 MSB first, one bclk after each lrck edge, on both channels; then 0s to frame end; underrun=0 for the first frame and pulses at the second frame start.
REQ-038 Hold read_enable=0 for DEPTH+1 left frames -> DEPTH samples are retained in order, overrun=1, and the extra sample is lost.
REQ-039 Fill the TX FIFO (4 writes) -> write_ready=0; a 5th write_enable is ignored; a simultaneous push and pop while full keeps count=4 and preserves order.
REQ-040 Toggle lrck after 10 bits -> no push occurs; the next full frame is received correctly.
REQ-041 Assert reset mid-frame with both FIFOs holding data -> all REQ-030 values hold, and the first complete frame after release is received correctly.
